crack_supervisor: RTL and testbench

//   Parametrised brute-force password search controller for the pancham MD5 core.

---
 rtl/crack_supervisor_if.sv | 22 ++
 rtl/crack_supervisor.sv | 152 +++++++++++++++
 tb/tb_crack_supervisor.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/crack_supervisor_if.sv
// Handshake bundle between the crack supervisor (master) and an external hash core (slave).
interface crack_supervisor_if #(
  parameter int MSG_W  = 128,
  parameter int HASH_W = 128
);
  logic [MSG_W-1:0]  core_msg;
  logic [7:0]        core_msg_width;
  logic              core_msg_valid;
  logic              core_ready;
  logic [HASH_W-1:0] core_hash;
  logic              core_hash_valid;

  modport master (
    output core_msg, core_msg_width, core_msg_valid,
    input  core_ready, core_hash, core_hash_valid
  );

  modport slave (
    input  core_msg, core_msg_width, core_msg_valid,
    output core_ready, core_hash, core_hash_valid
  );
endinterface

// File: rtl/crack_supervisor.sv
// Brute-force password search controller: odometer over a 62-symbol charset, one candidate
// in flight to an external hash core. Define CRACK_PROGRESS_EN to build the cand_count counter.
module crack_supervisor #(
  parameter int MAX_CHARS = 4,
  parameter int MSG_W     = 128,
  parameter int HASH_W    = 128,
  parameter int CNT_W     = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [HASH_W-1:0] target_hash,
  input  logic [4:0]        num_chars,
  crack_supervisor_if.master core,
  output logic              busy,
  output logic              found,
  output logic              done,
  output logic [MSG_W-1:0]  found_msg,
  output logic [CNT_W-1:0]  cand_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_CHECK, S_FOUND, S_EXHAUSTED
  } state_t;

  localparam logic [4:0] MAX_LEN = 5'(MAX_CHARS);

  state_t            state, state_nxt;
  logic [4:0]        len, len_clamped;
  logic [HASH_W-1:0] target, hash_reg;
  logic [5:0]        digits     [MAX_CHARS];
  logic [5:0]        digits_inc [MAX_CHARS];
  logic              all_max, match, issue_fire, can_start;
  logic [MSG_W-1:0]  cand_msg;

  function automatic logic [7:0] char_of(input logic [5:0] idx);
    logic [7:0] i8;
    i8 = {2'b00, idx};
    if (idx < 6'd26)      return 8'h61 + i8;
    else if (idx < 6'd52) return 8'h41 + (i8 - 8'd26);
    else                  return 8'h30 + (i8 - 8'd52);
  endfunction

  always_comb begin
    len_clamped = num_chars;
    if (num_chars == 5'd0)         len_clamped = 5'd1;
    else if (num_chars > MAX_LEN)  len_clamped = MAX_LEN;
  end

  // Odometer increment, exhaustion detect and message packing share one walk over the digits
  always_comb begin
    logic carry;
    carry    = 1'b1;
    all_max  = 1'b1;
    cand_msg = '0;
    for (int k = 0; k < MAX_CHARS; k++) begin
      digits_inc[k] = digits[k];
      if (k < int'(len)) begin
        all_max = all_max & (digits[k] == 6'd61);
        if (carry) begin
          if (digits[k] == 6'd61) begin
            digits_inc[k] = 6'd0;
          end else begin
            digits_inc[k] = digits[k] + 6'd1;
            carry         = 1'b0;
          end
        end
        cand_msg = (cand_msg << 8) | MSG_W'(char_of(digits[k]));
      end
    end
  end

  assign match      = (hash_reg == target);
  assign can_start  = start && ((state == S_IDLE) || (state == S_FOUND) || (state == S_EXHAUSTED));
  assign issue_fire = (state == S_ISSUE) && core.core_ready && !abort;
  assign busy       = (state == S_ISSUE) || (state == S_WAIT) || (state == S_CHECK);

  assign core.core_msg       = cand_msg;
  assign core.core_msg_width = {len, 3'b000};
  assign core.core_msg_valid = issue_fire;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:      if (start) state_nxt = S_ISSUE;
      S_ISSUE:     if (core.core_ready) state_nxt = S_WAIT;
      S_WAIT:      if (core.core_hash_valid) state_nxt = S_CHECK;
      S_CHECK: begin
        if (match)        state_nxt = S_FOUND;
        else if (all_max) state_nxt = S_EXHAUSTED;
        else              state_nxt = S_ISSUE;
      end
      S_FOUND,
      S_EXHAUSTED: if (start) state_nxt = S_ISSUE;
      default:     state_nxt = S_IDLE;
    endcase
    if (abort) state_nxt = S_IDLE;
  end

  // abort wins over start and core events; a start while busy falls through untouched
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      target    <= '0;
      len       <= '0;
      hash_reg  <= '0;
      found     <= 1'b0;
      done      <= 1'b0;
      found_msg <= '0;
      for (int k = 0; k < MAX_CHARS; k++) digits[k] <= 6'd0;
    end else if (abort) begin
      found     <= 1'b0;
      done      <= 1'b0;
      found_msg <= '0;
    end else if (can_start) begin
      target    <= target_hash;
      len       <= len_clamped;
      found     <= 1'b0;
      done      <= 1'b0;
      found_msg <= '0;
      for (int k = 0; k < MAX_CHARS; k++) digits[k] <= 6'd0;
    end else begin
      if ((state == S_WAIT) && core.core_hash_valid) hash_reg <= core.core_hash;
      if (state == S_CHECK) begin
        if (match) begin
          found     <= 1'b1;
          found_msg <= cand_msg;
        end else if (all_max) begin
          done <= 1'b1;
        end else begin
          for (int k = 0; k < MAX_CHARS; k++) digits[k] <= digits_inc[k];
        end
      end
    end
  end

`ifdef CRACK_PROGRESS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                  cand_count <= '0;
    else if (abort || can_start)   cand_count <= '0;
    else if (issue_fire && (cand_count != '1)) cand_count <= cand_count + 1'b1;
  end
`else
  assign cand_count = '0;
`endif

endmodule

// File: tb/tb_crack_supervisor.sv
// Directed bench for crack_supervisor; a stand-in hash core returns msg XOR KEY after core_lat cycles.
module tb_crack_supervisor;

  localparam logic [127:0] KEY = 128'hdeadbeef_01234567_89abcdef_5a5aa5a5;
`ifdef CRACK_PROGRESS_EN
  localparam bit PROG = 1'b1;
`else
  localparam bit PROG = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [127:0] target_hash = '0;
  logic [4:0]   num_chars = '0;
  logic         busy, found, done;
  logic [127:0] found_msg;
  logic [31:0]  cand_count;

  int vectors = 0;
  int miscompares = 0;
  int core_lat = 2;

  crack_supervisor_if #(.MSG_W(128), .HASH_W(128)) bus ();

  crack_supervisor #(.MAX_CHARS(4), .MSG_W(128), .HASH_W(128), .CNT_W(32)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .abort       (abort),
    .target_hash (target_hash),
    .num_chars   (num_chars),
    .core        (bus),
    .busy        (busy),
    .found       (found),
    .done        (done),
    .found_msg   (found_msg),
    .cand_count  (cand_count)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] fake_md5(input logic [127:0] m);
    return m ^ KEY;
  endfunction

  function automatic logic [127:0] exp_cnt(input int n);
    return PROG ? 128'(n) : 128'd0;
  endfunction

  // Stand-in core: one response per issued message, keeps running across abort/reset
  logic         pend = 1'b0;
  int           pend_cnt = 0;
  logic [127:0] pend_msg = '0;
  always @(posedge clk) begin
    bus.core_hash_valid <= 1'b0;
    if (bus.core_msg_valid) begin
      pend     <= 1'b1;
      pend_cnt <= core_lat;
      pend_msg <= bus.core_msg;
    end else if (pend) begin
      if (pend_cnt <= 1) begin
        bus.core_hash_valid <= 1'b1;
        bus.core_hash       <= fake_md5(pend_msg);
        pend                <= 1'b0;
      end else begin
        pend_cnt <= pend_cnt - 1;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [4:0] n, input logic [127:0] t);
    num_chars   = n;
    target_hash = t;
    start       = 1'b1;
    tick(1);
    start       = 1'b0;
  endtask

  task automatic wait_result(input string tag, input int max_cycles);
    int n = 0;
    while (!(found || done) && n < max_cycles) begin
      tick(1);
      n++;
    end
    check_output({tag, "_finished"}, 128'(found | done), 128'd1);
  endtask

  initial begin
    bus.core_ready = 1'b1;

    tick(2);
    check_output("rst_busy",  128'(busy), 128'd0);
    check_output("rst_found", 128'(found), 128'd0);
    check_output("rst_done",  128'(done), 128'd0);
    check_output("rst_fmsg",  found_msg, 128'd0);
    check_output("rst_msg",   bus.core_msg, 128'd0);
    check_output("rst_width", 128'(bus.core_msg_width), 128'd0);
    check_output("rst_valid", 128'(bus.core_msg_valid), 128'd0);
    check_output("rst_cnt",   128'(cand_count), 128'd0);
    reset_n = 1'b1;
    tick(1);

    $display("[TB] single char match 'a'");
    apply_stimulus(5'd1, fake_md5(128'h61));
    check_output("a_busy",  128'(busy), 128'd1);
    check_output("a_width", 128'(bus.core_msg_width), 128'd8);
    check_output("a_msg",   bus.core_msg, 128'h61);
    wait_result("a", 200);
    check_output("a_found", 128'(found), 128'd1);
    check_output("a_done",  128'(done), 128'd0);
    check_output("a_fmsg",  found_msg, 128'h61);
    check_output("a_cnt",   128'(cand_count), exp_cnt(1));
    check_output("a_idle",  128'(busy), 128'd0);

    $display("[TB] two char match 'ab', restart from FOUND, start while busy ignored");
    apply_stimulus(5'd2, fake_md5(128'h6162));
    check_output("ab_found_clr", 128'(found), 128'd0);
    check_output("ab_width", 128'(bus.core_msg_width), 128'd16);
    check_output("ab_msg0",  bus.core_msg, 128'h6161);
    tick(3);
    apply_stimulus(5'd1, 128'h0);
    num_chars = 5'd2;
    check_output("ab_ignore_width", 128'(bus.core_msg_width), 128'd16);
    wait_result("ab", 2000);
    check_output("ab_found", 128'(found), 128'd1);
    check_output("ab_fmsg",  found_msg, 128'h6162);
    check_output("ab_cnt",   128'(cand_count), exp_cnt(63));

    $display("[TB] single char exhaustion");
    apply_stimulus(5'd1, 128'h0);
    wait_result("ex", 2000);
    check_output("ex_done",  128'(done), 128'd1);
    check_output("ex_found", 128'(found), 128'd0);
    check_output("ex_cnt",   128'(cand_count), exp_cnt(62));
    check_output("ex_last",  bus.core_msg, 128'h39);
    check_output("ex_width", 128'(bus.core_msg_width), 128'd8);

    $display("[TB] length clamping");
    apply_stimulus(5'd0, 128'h0);
    check_output("len0_width", 128'(bus.core_msg_width), 128'd8);
    check_output("len0_done_clr", 128'(done), 128'd0);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    tick(10);
    apply_stimulus(5'd9, 128'h0);
    check_output("len9_width", 128'(bus.core_msg_width), 128'd32);
    check_output("len9_msg",   bus.core_msg, 128'h61616161);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    tick(10);

    $display("[TB] abort beats start in the same cycle");
    abort = 1'b1;
    start = 1'b1;
    num_chars = 5'd1;
    tick(1);
    abort = 1'b0;
    start = 1'b0;
    check_output("abst_busy", 128'(busy), 128'd0);

    $display("[TB] abort during WAIT");
    core_lat = 20;
    apply_stimulus(5'd3, 128'h0);
    tick(3);
    check_output("ab3_busy_pre", 128'(busy), 128'd1);
    check_output("ab3_width", 128'(bus.core_msg_width), 128'd24);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check_output("ab3_busy",  128'(busy), 128'd0);
    check_output("ab3_found", 128'(found), 128'd0);
    check_output("ab3_done",  128'(done), 128'd0);
    check_output("ab3_cnt",   128'(cand_count), 128'd0);
    tick(30);
    check_output("ab3_late_busy",  128'(busy), 128'd0);
    check_output("ab3_late_found", 128'(found), 128'd0);
    check_output("ab3_late_valid", 128'(bus.core_msg_valid), 128'd0);

    $display("[TB] reset during WAIT then clean restart");
    apply_stimulus(5'd1, fake_md5(128'h62));
    tick(3);
    check_output("rw_busy_pre", 128'(busy), 128'd1);
    reset_n = 1'b0;
    #1;
    check_output("rw_busy",  128'(busy), 128'd0);
    check_output("rw_msg",   bus.core_msg, 128'd0);
    check_output("rw_width", 128'(bus.core_msg_width), 128'd0);
    check_output("rw_cnt",   128'(cand_count), 128'd0);
    tick(2);
    reset_n = 1'b1;
    tick(30);
    check_output("rw_idle", 128'(busy), 128'd0);
    core_lat = 2;
    apply_stimulus(5'd1, fake_md5(128'h62));
    wait_result("rb", 200);
    check_output("rb_found", 128'(found), 128'd1);
    check_output("rb_fmsg",  found_msg, 128'h62);
    check_output("rb_cnt",   128'(cand_count), exp_cnt(2));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
